// File: rtl/morse_char_assembler.sv
// Collects dot/dash pulses into a pattern, translates it to ASCII on a letter gap and writes the
// result (plus word spaces) into the display FIFO. Build option: MORSE_UNKNOWN_CHAR_EN emits '?'.
module morse_char_assembler #(
    parameter int unsigned MAX_SYM = 5,
    parameter int unsigned CHAR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dot,
    input  logic              dash,
    input  logic              lg,
    input  logic              wg,
    input  logic              full,
    output logic [CHAR_W-1:0] char_data,
    output logic              char_wr,
    output logic              busy,
    output logic              err
);

    localparam int unsigned CntW = $clog2(MAX_SYM + 1);
    localparam logic [CHAR_W-1:0] Space   = CHAR_W'(8'h20);
    localparam logic [CHAR_W-1:0] Unknown = CHAR_W'(8'h3f);

`ifdef MORSE_UNKNOWN_CHAR_EN
    localparam bit UnknownEn = 1'b1;
`else
    localparam bit UnknownEn = 1'b0;
`endif

    typedef enum logic [1:0] {StCollect, StEmitChar, StEmitSpace} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_acc;
    logic [MAX_SYM-1:0]  sym_q, sym_d, sym_acc;
    logic                bad_q, bad_d, bad_acc;
    logic                last_space_q, last_space_d;
    logic                space_pend_q, space_pend_d;
    logic [CHAR_W-1:0]   char_q, char_d;
    logic                err_q, err_d;
    logic                any_in, letter_end, lk_ok;
    logic [7:0]          lk_char;

    // Key is {symbol count, pattern}; first symbol is the MSB of the valid bits, dash = 1.
    function automatic logic [8:0] lookup(input logic [7:0] key);
        case (key)
            8'b001_00000: lookup = {1'b1, 8'h45}; // E
            8'b001_00001: lookup = {1'b1, 8'h54}; // T
            8'b010_00001: lookup = {1'b1, 8'h41}; // A
            8'b010_00000: lookup = {1'b1, 8'h49}; // I
            8'b010_00011: lookup = {1'b1, 8'h4d}; // M
            8'b010_00010: lookup = {1'b1, 8'h4e}; // N
            8'b011_00100: lookup = {1'b1, 8'h44}; // D
            8'b011_00110: lookup = {1'b1, 8'h47}; // G
            8'b011_00101: lookup = {1'b1, 8'h4b}; // K
            8'b011_00111: lookup = {1'b1, 8'h4f}; // O
            8'b011_00010: lookup = {1'b1, 8'h52}; // R
            8'b011_00000: lookup = {1'b1, 8'h53}; // S
            8'b011_00001: lookup = {1'b1, 8'h55}; // U
            8'b011_00011: lookup = {1'b1, 8'h57}; // W
            8'b100_01000: lookup = {1'b1, 8'h42}; // B
            8'b100_01010: lookup = {1'b1, 8'h43}; // C
            8'b100_00010: lookup = {1'b1, 8'h46}; // F
            8'b100_00000: lookup = {1'b1, 8'h48}; // H
            8'b100_00111: lookup = {1'b1, 8'h4a}; // J
            8'b100_00100: lookup = {1'b1, 8'h4c}; // L
            8'b100_00110: lookup = {1'b1, 8'h50}; // P
            8'b100_01101: lookup = {1'b1, 8'h51}; // Q
            8'b100_00001: lookup = {1'b1, 8'h56}; // V
            8'b100_01001: lookup = {1'b1, 8'h58}; // X
            8'b100_01011: lookup = {1'b1, 8'h59}; // Y
            8'b100_01100: lookup = {1'b1, 8'h5a}; // Z
            8'b101_11111: lookup = {1'b1, 8'h30};
            8'b101_01111: lookup = {1'b1, 8'h31};
            8'b101_00111: lookup = {1'b1, 8'h32};
            8'b101_00011: lookup = {1'b1, 8'h33};
            8'b101_00001: lookup = {1'b1, 8'h34};
            8'b101_00000: lookup = {1'b1, 8'h35};
            8'b101_10000: lookup = {1'b1, 8'h36};
            8'b101_11000: lookup = {1'b1, 8'h37};
            8'b101_11100: lookup = {1'b1, 8'h38};
            8'b101_11110: lookup = {1'b1, 8'h39};
            default:      lookup = 9'h000;
        endcase
    endfunction

    // Accumulator as it stands after this cycle's symbol, so a symbol coincident with a gap counts.
    always_comb begin
        cnt_acc = cnt_q;
        sym_acc = sym_q;
        bad_acc = bad_q;
        if (dot && dash) begin
            bad_acc = 1'b1;
        end else if (dot || dash) begin
            if (cnt_q == CntW'(MAX_SYM)) begin
                bad_acc = 1'b1;
            end else begin
                cnt_acc = cnt_q + CntW'(1);
                sym_acc = {sym_q[MAX_SYM-2:0], dash};
            end
        end
    end

    always_comb begin
        {lk_ok, lk_char} = lookup({3'(cnt_acc), 5'(sym_acc)});
        if (bad_acc) begin
            lk_ok = 1'b0;
        end
    end

    assign any_in     = dot | dash | lg | wg;
    assign letter_end = (lg || wg) && (cnt_acc != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCollect: begin
                if (letter_end) begin
                    if (lk_ok || UnknownEn) begin
                        state_d = StEmitChar;
                    end else if (wg && !last_space_q) begin
                        state_d = StEmitSpace;
                    end
                end else if (wg && !last_space_q) begin
                    state_d = StEmitSpace;
                end
            end
            StEmitChar: begin
                if (!full) begin
                    state_d = space_pend_q ? StEmitSpace : StCollect;
                end
            end
            StEmitSpace: begin
                if (!full) begin
                    state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_comb begin
        busy      = (state_q != StCollect);
        char_wr   = (state_q != StCollect) && !full;
        char_data = char_q;
        err       = err_q;
    end

    always_comb begin
        cnt_d        = cnt_q;
        sym_d        = sym_q;
        bad_d        = bad_q;
        char_d       = char_q;
        last_space_d = last_space_q;
        space_pend_d = space_pend_q;
        err_d        = 1'b0;
        unique case (state_q)
            StCollect: begin
                cnt_d = cnt_acc;
                sym_d = sym_acc;
                bad_d = bad_acc;
                if (letter_end) begin
                    cnt_d        = '0;
                    sym_d        = '0;
                    bad_d        = 1'b0;
                    err_d        = !lk_ok;
                    space_pend_d = wg;
                end
            end
            StEmitChar: begin
                err_d = any_in;
                if (!full) begin
                    last_space_d = 1'b0;
                    space_pend_d = 1'b0;
                end
            end
            StEmitSpace: begin
                err_d = any_in;
                if (!full) begin
                    last_space_d = 1'b1;
                end
            end
            default: ;
        endcase
        // Output character is loaded only on entry to an emit state and held while blocked.
        if (state_d != state_q) begin
            if (state_d == StEmitChar) begin
                char_d = lk_ok ? CHAR_W'(lk_char) : Unknown;
            end else if (state_d == StEmitSpace) begin
                char_d = Space;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            sym_q        <= '0;
            bad_q        <= 1'b0;
            char_q       <= '0;
            last_space_q <= 1'b1;
            space_pend_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sym_q        <= sym_d;
            bad_q        <= bad_d;
            char_q       <= char_d;
            last_space_q <= last_space_d;
            space_pend_q <= space_pend_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_morse_char_assembler.sv
// Scoreboard bench for morse_char_assembler: expected characters are queued as stimulus is
// driven and compared against the FIFO writes captured by a negedge monitor.
module tb_morse_char_assembler;

    logic       clk;
    logic       reset;
    logic       dot, dash, lg, wg, full;
    logic [7:0] char_data;
    logic       char_wr, busy, err;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         err_seen = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    logic [7:0] e, g;

    morse_char_assembler #(
        .MAX_SYM(5),
        .CHAR_W (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .dot      (dot),
        .dash     (dash),
        .lg       (lg),
        .wg       (wg),
        .full     (full),
        .char_data(char_data),
        .char_wr  (char_wr),
        .busy     (busy),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (char_wr === 1'b1) begin
            got_q.push_back(char_data);
            got_cyc_q.push_back(cyc);
        end
        if (err === 1'b1) err_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    // Inputs are driven 1 time unit after posedge and held for one cycle.
    task automatic pulse(input logic d, input logic da, input logic l, input logic w);
        dot = d; dash = da; lg = l; wg = w;
        @(posedge clk); #1;
        dot = 1'b0; dash = 1'b0; lg = 1'b0; wg = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        reset = 1'b1; full = 1'b0;
        idle(3);
        tests++; if (char_wr !== 1'b0) begin fails++; $display("FAIL reset_wr: got %b, required 0", char_wr); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b, required 0", err); end
        tests++; if (char_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h, required 00", char_data); end
        reset = 1'b0;
        idle(1);
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_letter_a;
        int t;
        int c;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        t = cyc;
        pulse(0, 0, 1, 0);
        exp_q.push_back(8'h41);
        idle(4);
        c = (got_cyc_q.size() > 0) ? got_cyc_q[0] : -1;
        tests++; if (c != t + 1) begin fails++; $display("FAIL a_latency: got cycle %0d, required %0d", c, t + 1); end
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL a_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL a_char: got %h, required %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_word_zero;
        int t;
        int c0, c1;
        repeat (5) pulse(0, 1, 0, 0);
        t = cyc;
        pulse(0, 0, 0, 1);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h20);
        idle(4);
        c0 = (got_cyc_q.size() > 0) ? got_cyc_q[0] : -1;
        c1 = (got_cyc_q.size() > 1) ? got_cyc_q[1] : -1;
        tests++; if (c0 != t + 1) begin fails++; $display("FAIL zero_char_cycle: got %0d, required %0d", c0, t + 1); end
        tests++; if (c1 != t + 2) begin fails++; $display("FAIL zero_space_cycle: got %0d, required %0d", c1, t + 2); end
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL zero_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL zero_char: got %h, required %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
        pulse(0, 0, 0, 1);
        idle(3);
        tests++;
        if (got_q.size() != 0) begin fails++; $display("FAIL double_space: got %0d writes, required 0", got_q.size()); end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_full_stall;
        full = 1'b1;
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL stall_busy: got %b, required 1", busy); end
            tests++; if (char_data !== 8'h49) begin fails++; $display("FAIL stall_data: got %h, required 49", char_data); end
            tests++; if (char_wr !== 1'b0) begin fails++; $display("FAIL stall_wr: got %b, required 0", char_wr); end
            @(posedge clk); #1;
        end
        full = 1'b0;
        exp_q.push_back(8'h49);
        idle(3);
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL stall_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL stall_char: got %h, required %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_invalid;
        int e0;
        e0 = err_seen;
        repeat (6) pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
`ifdef MORSE_UNKNOWN_CHAR_EN
        exp_q.push_back(8'h3f);
`endif
        idle(4);
        tests++; if (err_seen - e0 != 1) begin fails++; $display("FAIL invalid_err: got %0d pulses, required 1", err_seen - e0); end
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL invalid_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL invalid_char: got %h, required %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_busy_drop;
        int e0;
        full = 1'b1;
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        e0 = err_seen;
        pulse(0, 1, 0, 0);
        idle(1);
        tests++; if (err_seen - e0 != 1) begin fails++; $display("FAIL drop_err: got %0d pulses, required 1", err_seen - e0); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL drop_busy: got %b, required 1", busy); end
        full = 1'b0;
        exp_q.push_back(8'h45);
        idle(2);
        pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0);
        exp_q.push_back(8'h54);
        idle(3);
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL drop_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL drop_char: got %h, required %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_back_to_back;
        int e0;
        e0 = err_seen;
        repeat (3) pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0); exp_q.push_back(8'h53); idle(1);
        repeat (3) pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 0); exp_q.push_back(8'h4f); idle(1);
        repeat (2) pulse(1, 0, 0, 0);
        pulse(1, 0, 1, 0); exp_q.push_back(8'h53); idle(1);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 1); exp_q.push_back(8'h41); exp_q.push_back(8'h20); idle(2);
        repeat (2) pulse(0, 1, 0, 0);
        pulse(0, 0, 1, 1); exp_q.push_back(8'h4d); exp_q.push_back(8'h20); idle(3);
        tests++; if (err_seen != e0) begin fails++; $display("FAIL b2b_err: got %0d pulses, required 0", err_seen - e0); end
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL b2b_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL b2b_char: got %h, required %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_reset_mid;
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        exp_q.push_back(8'h45);
        idle(2);
        full = 1'b1;
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        full = 1'b0;
        @(negedge clk);
        tests++; if (char_wr !== 1'b0) begin fails++; $display("FAIL rmid_wr: got %b, required 0", char_wr); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b, required 0", busy); end
        tests++; if (char_data !== 8'h00) begin fails++; $display("FAIL rmid_data: got %h, required 00", char_data); end
        @(posedge clk); #1;
        pulse(0, 0, 0, 1);
        idle(3);
        tests++;
        if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL rmid_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL rmid_char: got %h, required %h", g, e); end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    initial begin
        reset = 1'b1; full = 1'b0;
        dot = 1'b0; dash = 1'b0; lg = 1'b0; wg = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_letter_a();
        test_word_zero();
        test_full_stall();
        test_invalid();
        test_busy_drop();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
